// File: rtl/ppu_video_pkg.sv
// Shared video constants, colour type, lock states and the 2C02 master palette
// for the PPU -> VGA scan doubler.
package ppu_video_pkg;

    localparam logic [9:0] H_ACTIVE  = 10'd640;
    localparam logic [9:0] H_FRONT   = 10'd16;
    localparam logic [9:0] H_SYNC    = 10'd96;
    localparam logic [9:0] H_BACK    = 10'd48;
    localparam logic [9:0] V_ACTIVE  = 10'd480;
    localparam logic [9:0] V_FRONT   = 10'd10;
    localparam logic [9:0] V_SYNC    = 10'd2;
    localparam logic [9:0] V_BACK    = 10'd33;
    localparam logic [9:0] SRC_WIDTH = 10'd256;
    localparam logic [9:0] H_BORDER  = 10'd64;

    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] HS_START = H_ACTIVE + H_FRONT;
    localparam logic [9:0] HS_END   = HS_START + H_SYNC - 10'd1;
    localparam logic [9:0] VS_START = V_ACTIVE + V_FRONT;
    localparam logic [9:0] VS_END   = VS_START + V_SYNC - 10'd1;
    // Last dot of the doubled image: every source pixel covers two dots.
    localparam logic [9:0] IMG_END  = H_BORDER + SRC_WIDTH + SRC_WIDTH - 10'd1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam rgb24_t PALETTE [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFFFFFF, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    function automatic rgb24_t half_intensity(input rgb24_t c);
        return {1'b0, c.r[7:1], 1'b0, c.g[7:1], 1'b0, c.b[7:1]};
    endfunction

endpackage

// File: rtl/ppu_vga_scan_doubler_if.sv
// PPU pixel write bus feeding the scan doubler; the PPU is master.
interface ppu_vga_scan_doubler_if;

    logic       pixelValid;
    logic [5:0] pixelIndex;
    logic [7:0] srcX;
    logic       srcLine;
    logic       frameSync;

    modport master (
        output pixelValid, pixelIndex, srcX, srcLine, frameSync
    );

    modport slave (
        input pixelValid, pixelIndex, srcX, srcLine, frameSync
    );

endinterface

// File: rtl/ppu_line_buffer.sv
// Dual-bank 2x256x6 line store: one write port, one registered read port.
// Unreset contents so it maps onto block RAM.
module ppu_line_buffer (
    input  logic       clock,
    input  logic       wrEn,
    input  logic       wrBank,
    input  logic [7:0] wrAddr,
    input  logic [5:0] wrData,
    input  logic       rdEn,
    input  logic       rdBank,
    input  logic [7:0] rdAddr,
    output logic [5:0] rdData
);

    logic [5:0] mem [512];

    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[{wrBank, wrAddr}] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[{rdBank, rdAddr}];
        end
    end

endmodule

// File: rtl/ppu_vga_scan_doubler.sv
// Replays each 256-pixel PPU line twice, pixel-doubled, as 640x480 VGA with
// palette lookup. Optional macro SCANLINE_DIM_EN halves intensity on odd lines.
module ppu_vga_scan_doubler
    import ppu_video_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    ppu_vga_scan_doubler_if.slave     pix,
    input  logic                      vgaStrobe,
    output logic [7:0]                red,
    output logic [7:0]                green,
    output logic [7:0]                blue,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      blank,
    output logic                      locked,
    output logic                      syncSlip
);

    lock_state_t state, stateNext;
    logic        slipNext;
    logic [9:0]  hCount, vCount;
    logic        atOrigin;
    logic        rdBank;

    assign atOrigin = (hCount == '0) && (vCount == '0);
    assign locked   = (state == LOCKED);

    always_comb begin
        stateNext = state;
        slipNext  = 1'b0;
        case (state)
            UNLOCKED: if (pix.frameSync) stateNext = LOCKED;
            LOCKED:   if (pix.frameSync && !atOrigin) slipNext = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= UNLOCKED;
            syncSlip <= 1'b0;
        end else begin
            state    <= stateNext;
            syncSlip <= slipNext;
        end
    end

    // frameSync realigns in any state and takes priority over a dot advance.
    always_ff @(posedge clock) begin
        if (reset || pix.frameSync) begin
            hCount <= '0;
            vCount <= '0;
        end else if (vgaStrobe) begin
            if (hCount == H_TOTAL - 10'd1) begin
                hCount <= '0;
                vCount <= (vCount == V_TOTAL - 10'd1) ? '0 : vCount + 10'd1;
            end else begin
                hCount <= hCount + 10'd1;
            end
        end
    end

    // The bank opposite the PPU's is captured once per VGA line pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdBank <= 1'b0;
        end else if (vgaStrobe && hCount == '0 && !vCount[0]) begin
            rdBank <= ~pix.srcLine;
        end
    end

    logic [9:0] hOff;
    logic [7:0] rdAddr;
    logic       inWindow;
    logic [5:0] rdData;

    assign hOff     = hCount - H_BORDER;
    assign rdAddr   = hOff[8:1];
    assign inWindow = (vCount < V_ACTIVE) && (hCount >= H_BORDER) && (hCount <= IMG_END);

    ppu_line_buffer u_line_buffer (
        .clock  (clock),
        .wrEn   (pix.pixelValid),
        .wrBank (pix.srcLine),
        .wrAddr (pix.srcX),
        .wrData (pix.pixelIndex),
        .rdEn   (vgaStrobe),
        .rdBank (rdBank),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    logic unusedBits;
    assign unusedBits = ^{rdData[4], hOff[9], hOff[0]};

    logic winS1, hsS1, vsS1, blankS1;
`ifdef SCANLINE_DIM_EN
    logic oddS1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            winS1   <= 1'b0;
            hsS1    <= 1'b1;
            vsS1    <= 1'b1;
            blankS1 <= 1'b1;
`ifdef SCANLINE_DIM_EN
            oddS1   <= 1'b0;
`endif
        end else if (vgaStrobe) begin
            winS1   <= inWindow;
            hsS1    <= !((hCount >= HS_START) && (hCount <= HS_END));
            vsS1    <= !((vCount >= VS_START) && (vCount <= VS_END));
            blankS1 <= !((hCount < H_ACTIVE) && (vCount < V_ACTIVE));
`ifdef SCANLINE_DIM_EN
            oddS1   <= vCount[0];
`endif
        end
    end

    rgb24_t pixel;

    always_comb begin
        pixel = '0;
        if (winS1 && rdData[5] && state == LOCKED) begin
            pixel = PALETTE[{2'b00, rdData[3:0]}];
        end
`ifdef SCANLINE_DIM_EN
        if (oddS1) begin
            pixel = half_intensity(pixel);
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            blank <= 1'b1;
        end else if (vgaStrobe) begin
            red   <= pixel.r;
            green <= pixel.g;
            blue  <= pixel.b;
            hsync <= hsS1;
            vsync <= vsS1;
            blank <= blankS1;
        end
    end

endmodule

// File: tb/tb_ppu_vga_scan_doubler.sv
// Bench for ppu_vga_scan_doubler: dot-level scoreboard plus a table of image spot checks.
module tb_ppu_vga_scan_doubler;

`ifdef SCANLINE_DIM_EN
    localparam bit DIM = 1'b1;
`else
    localparam bit DIM = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       vgaStrobe;
    logic [7:0] red, green, blue;
    logic       hsync, vsync, blank, locked, syncSlip;

    always #5 clock = ~clock;

    ppu_vga_scan_doubler_if pix ();

    ppu_vga_scan_doubler dut (
        .clock     (clock),
        .reset     (reset),
        .pix       (pix),
        .vgaStrobe (vgaStrobe),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank     (blank),
        .locked    (locked),
        .syncSlip  (syncSlip)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } vid_t;

    typedef struct {
        vid_t        v;
        int unsigned h;
        int unsigned line;
    } exp_t;

    typedef struct {
        string       name;
        logic        doWrite;
        logic [7:0]  x;
        logic [5:0]  idx;
        int unsigned dot;
        logic [23:0] expRgb;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[12];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned mh = 0, mv = 0;
    logic        mLocked = 1'b0;
    logic        mBank = 1'b0;
    logic [5:0]  bm [2][256];
    logic [23:0] pal16 [16];
    logic [23:0] cap0 [800];
    logic [23:0] cap1 [800];
    vid_t        lastExp;
    logic        trackHs = 1'b0;
    int unsigned hsLows = 0, hsFirst = 0, hsLast = 0, hsUnlocked = 0;

    function automatic logic [23:0] dimmed(input logic [23:0] c, input int unsigned line);
        if (DIM && line[0]) return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
        return c;
    endfunction

    function automatic vid_t model_dot(input int unsigned h, input int unsigned v);
        vid_t        e;
        logic [5:0]  px;
        int unsigned col;
        e.hs  = !(h >= 656 && h <= 751);
        e.vs  = !(v == 490 || v == 491);
        e.bl  = !(h < 640 && v < 480);
        e.rgb = '0;
        if (v < 480 && h >= 64 && h < 576) begin
            col = (h - 64) / 2;
            px  = bm[mBank][col];
            if (px[5]) e.rgb = dimmed(pal16[px[3:0]], v);
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic compare_out(input exp_t e);
        vid_t act, want;
        act  = {red, green, blue, hsync, vsync, blank};
        want = e.v;
        if (!mLocked) want.rgb = '0;
        lastExp = want;
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL dot h=%0d v=%0d: got %h expected %h", e.h, e.line, act, want);
        end
        if (e.line == 0) cap0[e.h] = act.rgb;
        else if (e.line == 1) cap1[e.h] = act.rgb;
        if (trackHs && e.line == 0 && act.hs == 1'b0) begin
            if (hsLows == 0) hsFirst = e.h;
            hsLast = e.h;
            hsLows++;
        end
        if (!mLocked && act.hs == 1'b0) hsUnlocked++;
    endtask

    task automatic strobe_dot();
        exp_t e;
        e.v    = model_dot(mh, mv);
        e.h    = mh;
        e.line = mv;
        sbq.push_back(e);
        if (mh == 0 && mv % 2 == 0) mBank = ~pix.srcLine;
        if (mh == 799) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
        end else begin
            mh++;
        end
        vgaStrobe = 1'b1;
        tick();
        vgaStrobe = 1'b0;
        if (sbq.size() >= 2) compare_out(sbq.pop_front());
    endtask

    task automatic run(input int unsigned n, input int unsigned gap);
        for (int unsigned i = 0; i < n; i++) begin
            strobe_dot();
            for (int unsigned g = 0; g < gap; g++) begin
                tick();
                check("idle hold", {red, green, blue, hsync, vsync, blank}, lastExp);
            end
        end
    endtask

    task automatic frame_sync(input logic withStrobe, input logic expSlip);
        pix.frameSync = 1'b1;
        vgaStrobe     = withStrobe;
        tick();
        pix.frameSync = 1'b0;
        vgaStrobe     = 1'b0;
        sbq.delete();
        mh = 0;
        mv = 0;
        mLocked = 1'b1;
        check("syncSlip pulse", {31'd0, syncSlip}, {31'd0, expSlip});
        check("locked after frameSync", {31'd0, locked}, 32'd1);
        tick();
        check("syncSlip one cycle", {31'd0, syncSlip}, 32'd0);
    endtask

    task automatic write_px(input logic bank, input logic [7:0] x, input logic [5:0] idx);
        pix.srcLine    = bank;
        pix.pixelValid = 1'b1;
        pix.srcX       = x;
        pix.pixelIndex = idx;
        tick();
        pix.pixelValid = 1'b0;
        bm[bank][x]    = idx;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rgb"},    {8'd0, red, green, blue}, 32'd0);
        check({tag, " hsync"},  {31'd0, hsync}, 32'd1);
        check({tag, " vsync"},  {31'd0, vsync}, 32'd1);
        check({tag, " blank"},  {31'd0, blank}, 32'd1);
        check({tag, " locked"}, {31'd0, locked}, 32'd0);
        check({tag, " slip"},   {31'd0, syncSlip}, 32'd0);
    endtask

    initial begin
        pal16 = '{24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020,
                  24'hA81000, 24'h881400, 24'h503000, 24'h007800, 24'h006800, 24'h005800,
                  24'h004058, 24'h000000, 24'h000000, 24'h000000};
        tbl[0]  = '{"dot0 border",    1'b0, 8'd0,   6'h00, 0,   24'h000000};
        tbl[1]  = '{"dot63 border",   1'b0, 8'd0,   6'h00, 63,  24'h000000};
        tbl[2]  = '{"dot64 idx0",     1'b1, 8'd0,   6'h20, 64,  24'h7C7C7C};
        tbl[3]  = '{"dot65 idx0",     1'b0, 8'd0,   6'h00, 65,  24'h7C7C7C};
        tbl[4]  = '{"dot66 idx1",     1'b1, 8'd1,   6'h21, 66,  24'h0000FC};
        tbl[5]  = '{"dot68 bit4 ign", 1'b1, 8'd2,   6'h3C, 68,  24'h004058};
        tbl[6]  = '{"dot74 disabled", 1'b1, 8'd5,   6'h0A, 74,  24'h000000};
        tbl[7]  = '{"dot75 disabled", 1'b0, 8'd0,   6'h00, 75,  24'h000000};
        tbl[8]  = '{"dot264 col100",  1'b1, 8'd100, 6'h2A, 264, 24'h006800};
        tbl[9]  = '{"dot575 col255",  1'b1, 8'd255, 6'h26, 575, 24'hA81000};
        tbl[10] = '{"dot576 border",  1'b0, 8'd0,   6'h00, 576, 24'h000000};
        tbl[11] = '{"dot96 col16",    1'b0, 8'd0,   6'h00, 96,  24'h7C7C7C};

        foreach (bm[b, x]) bm[b][x] = '0;
        reset          = 1'b1;
        vgaStrobe      = 1'b0;
        pix.pixelValid = 1'b0;
        pix.pixelIndex = '0;
        pix.srcX       = '0;
        pix.srcLine    = 1'b0;
        pix.frameSync  = 1'b0;
        repeat (3) tick();
        check_reset_outputs("in reset");
        reset = 1'b0;
        tick();
        check_reset_outputs("after reset");

        // Free-running and unlocked: black picture, sync still toggles.
        run(1600, 0);
        check("unlocked hsync low dots", hsUnlocked, 32'd192);

        for (int unsigned i = 0; i < 256; i++) begin
            logic [7:0] xi;
            xi = 8'(i);
            write_px(1'b0, xi, {2'b10, xi[3:0]});
        end
        for (int unsigned k = 0; k < 12; k++) begin
            if (tbl[k].doWrite) write_px(1'b0, tbl[k].x, tbl[k].idx);
        end
        pix.srcLine = 1'b1;

        frame_sync(1'b0, 1'b0);
        trackHs = 1'b1;
        run(1600, 0);
        trackHs = 1'b0;
        check("hsync low count", hsLows, 32'd96);
        check("hsync first low", hsFirst, 32'd656);
        check("hsync last low", hsLast, 32'd751);

        for (int unsigned k = 0; k < 12; k++) begin
            check({tbl[k].name, " even"}, {8'd0, cap0[tbl[k].dot]}, {8'd0, tbl[k].expRgb});
            check({tbl[k].name, " odd"},  {8'd0, cap1[tbl[k].dot]}, {8'd0, dimmed(tbl[k].expRgb, 1)});
        end

        // Bank 1 shown on lines 2-3; toggling srcLine mid-pair must not switch banks.
        for (int unsigned i = 0; i < 256; i++) begin
            logic [7:0] xi;
            xi = 8'(i);
            write_px(1'b1, xi, {2'b10, ~xi[3:0]});
        end
        pix.srcLine = 1'b0;
        run(800, 0);
        pix.srcLine = 1'b1;
        run(800, 0);
        run(800, 0);

        run(100, 1);
        run(200, 0);
        frame_sync(1'b0, 1'b1);
        frame_sync(1'b0, 1'b0);
        run(700, 0);
        frame_sync(1'b1, 1'b1);
        run(800, 0);

        run(50, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sbq.delete();
        mh = 0;
        mv = 0;
        mLocked = 1'b0;
        mBank = 1'b0;
        check_reset_outputs("mid-frame reset");
        run(900, 0);
        frame_sync(1'b0, 1'b0);
        run(300, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
